// File: rtl/mtx_seq.sv
// mtx_seq: issue stage for the matrix unit. Replays a small VLIW program for
// a programmable number of passes, pairing load words with buffered operand vectors.
module mtx_seq #(
    parameter int unsigned OP_W       = 5,
    parameter int unsigned DATA_W     = 512,
    parameter int unsigned PROG_DEPTH = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned OP_LD_LO   = 1,
    parameter int unsigned OP_LD_HI   = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          prog_we,
    input  logic [$clog2(PROG_DEPTH)-1:0] prog_addr,
    input  logic [4*OP_W-1:0]             prog_wdata,
    input  logic [$clog2(PROG_DEPTH)-1:0] end_addr,
    input  logic [7:0]                    loop_cnt,
    input  logic                          start,
    input  logic                          abort,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_W-1:0]             in_data,
    output logic [4*OP_W-1:0]             vliw_inst,
    output logic                          inst_valid,
    output logic [DATA_W-1:0]             unit_in,
    output logic                          busy,
    output logic                          done,
    output logic                          prog_err,
    output logic [15:0]                   stall_cnt
);
    localparam int unsigned AW  = $clog2(PROG_DEPTH);
    localparam int unsigned IW  = 4 * OP_W;
    localparam int unsigned FAW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW  = FAW + 1;

    localparam logic [OP_W-1:0] LD_LO     = OP_W'(OP_LD_LO);
    localparam logic [OP_W-1:0] LD_HI     = OP_W'(OP_LD_HI);
    localparam logic [CW-1:0]   FIFO_FULL = CW'(FIFO_DEPTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [AW-1:0]     pc_q, pc_d, end_q, end_d;
    logic [7:0]        iter_q, iter_d, loop_q, loop_d;
    logic [IW-1:0]     vliw_q, vliw_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] unit_q, unit_d;
    logic              done_q, done_d;
    logic [15:0]       stall_q, stall_d;
    logic              perr_q, perr_d;

    logic [IW-1:0]     mem [PROG_DEPTH];
    logic [IW-1:0]     word;
    logic              need;

    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [FAW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]     cnt_q;
    logic              fifo_empty, fifo_full, push, pop;

    // Program memory: writes only land while idle.
    always_ff @(posedge clk) begin
        if (prog_we && state_q == IDLE) begin
            mem[prog_addr] <= prog_wdata;
        end
    end

    assign word = mem[pc_q];

    always_comb begin
        need = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (word[i*OP_W +: OP_W] >= LD_LO && word[i*OP_W +: OP_W] <= LD_HI) begin
                need = 1'b1;
            end
        end
    end

    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == FIFO_FULL);
    assign in_ready   = rst_n & ~fifo_full;
    assign push       = in_valid & in_ready & ~flush;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + FAW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + FAW'(1);
            cnt_q <= cnt_q + {{FAW{1'b0}}, push} - {{FAW{1'b0}}, pop};
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        iter_d  = iter_q;
        end_d   = end_q;
        loop_d  = loop_q;
        vliw_d  = '0;
        valid_d = 1'b0;
        unit_d  = unit_q;
        done_d  = 1'b0;
        stall_d = stall_q;
        perr_d  = perr_q;
        pop     = 1'b0;
        if (prog_we && state_q != IDLE) perr_d = 1'b1;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    pc_d    = '0;
                    iter_d  = '0;
                    end_d   = end_addr;
                    loop_d  = loop_cnt;
                    stall_d = '0;
                    perr_d  = 1'b0;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (need && fifo_empty) begin
                    if (stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
                end else begin
                    vliw_d  = word;
                    valid_d = 1'b1;
                    // All load slots of one word share a single popped vector.
                    if (need) begin
                        unit_d = fifo_mem[rd_ptr_q];
                        pop    = 1'b1;
                    end
                    if (pc_q == end_q) begin
                        if (iter_q == loop_q) begin
                            state_d = DONE;
                        end else begin
                            pc_d   = '0;
                            iter_d = iter_q + 8'd1;
                        end
                    end else begin
                        pc_d = pc_q + AW'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                done_d  = ~abort;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
            iter_q  <= '0;
            end_q   <= '0;
            loop_q  <= '0;
            vliw_q  <= '0;
            valid_q <= 1'b0;
            unit_q  <= '0;
            done_q  <= 1'b0;
            stall_q <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            iter_q  <= iter_d;
            end_q   <= end_d;
            loop_q  <= loop_d;
            vliw_q  <= vliw_d;
            valid_q <= valid_d;
            unit_q  <= unit_d;
            done_q  <= done_d;
            stall_q <= stall_d;
            perr_q  <= perr_d;
        end
    end

    assign vliw_inst  = vliw_q;
    assign inst_valid = valid_q;
    assign unit_in    = unit_q;
    assign done       = done_q;
    assign stall_cnt  = stall_q;
    assign prog_err   = perr_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mtx_seq.sv
// Bench for mtx_seq: queue-based reference model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic.
module tb_mtx_seq;
    localparam int unsigned OP_W = 5;
    localparam int unsigned DW   = 512;
    localparam int unsigned PD   = 32;
    localparam int unsigned FD   = 4;
    localparam int unsigned IW   = 4 * OP_W;
    localparam int unsigned AW   = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          prog_we = 1'b0;
    logic [AW-1:0] prog_addr = '0;
    logic [IW-1:0] prog_wdata = '0;
    logic [AW-1:0] end_addr = '0;
    logic [7:0]    loop_cnt = '0;
    logic          start = 1'b0, abort = 1'b0, flush = 1'b0, in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [IW-1:0] vliw_inst;
    logic          inst_valid, busy, done, prog_err;
    logic [DW-1:0] unit_in;
    logic [15:0]   stall_cnt;

    always #5 clk = ~clk;

    mtx_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_wdata(prog_wdata),
        .end_addr  (end_addr),
        .loop_cnt  (loop_cnt),
        .start     (start),
        .abort     (abort),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .vliw_inst (vliw_inst),
        .inst_valid(inst_valid),
        .unit_in   (unit_in),
        .busy      (busy),
        .done      (done),
        .prog_err  (prog_err),
        .stall_cnt (stall_cnt)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model state
    logic [IW-1:0] m_prog [PD];
    logic [DW-1:0] m_q [$];
    int            m_mode, m_pc, m_it, m_end, m_loop, e_stall;
    logic [IW-1:0] e_vliw;
    logic          e_valid, e_done, e_perr;
    logic [DW-1:0] e_unit;

    always @(posedge clk) begin
        logic [IW-1:0] w;
        bit            need, pop, push;
        int            op;
        if (!rst_n) begin
            m_mode = 0; m_pc = 0; m_it = 0; m_end = 0; m_loop = 0; e_stall = 0;
            e_vliw = '0; e_valid = 0; e_done = 0; e_perr = 0; e_unit = '0;
            m_q.delete();
        end else begin
            push = in_valid && (m_q.size() < FD) && !flush;
            pop = 0; e_vliw = '0; e_valid = 0; e_done = 0;
            if (m_mode != 0 && prog_we) e_perr = 1;
            if (m_mode == 0) begin
                if (prog_we) m_prog[prog_addr] = prog_wdata;
                if (start) begin
                    m_mode = 1; m_pc = 0; m_it = 0; m_end = int'(end_addr);
                    m_loop = int'(loop_cnt); e_stall = 0; e_perr = 0;
                end
            end else if (m_mode == 2) begin
                e_done = !abort;
                m_mode = 0;
            end else if (abort) begin
                m_mode = 0;
            end else begin
                w = m_prog[m_pc];
                need = 0;
                for (int i = 0; i < 4; i++) begin
                    op = int'((w >> (i * OP_W)) & 20'h1f);
                    if (op >= 1 && op <= 3) need = 1;
                end
                if (need && m_q.size() == 0) begin
                    e_stall = (e_stall == 65535) ? 65535 : e_stall + 1;
                end else begin
                    e_vliw = w; e_valid = 1;
                    if (need) begin e_unit = m_q[0]; pop = 1; end
                    if (m_pc == m_end) begin
                        if (m_it == m_loop) m_mode = 2;
                        else begin m_pc = 0; m_it++; end
                    end else m_pc++;
                end
            end
            if (flush) m_q.delete();
            else begin
                if (pop) void'(m_q.pop_front());
                if (push) m_q.push_back(in_data);
            end
        end
        #1;
        chk("m_vliw", vliw_inst, e_vliw);
        chk("m_valid", inst_valid, e_valid);
        chk("m_unit", unit_in, e_unit);
        chk("m_done", done, e_done);
        chk("m_busy", busy, m_mode != 0);
        chk("m_perr", prog_err, e_perr);
        chk("m_stall", stall_cnt, 16'(e_stall));
        chk("m_ready", in_ready, rst_n && (m_q.size() < FD));
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wr(input int a, input logic [IW-1:0] d);
        prog_we = 1; prog_addr = AW'(a); prog_wdata = d; tick(); prog_we = 0;
    endtask

    task automatic push1(input logic [DW-1:0] d);
        in_valid = 1; in_data = d; tick(); in_valid = 0;
    endtask

    task automatic go(input int e, input int l);
        end_addr = AW'(e); loop_cnt = 8'(l); start = 1; tick(); start = 0;
    endtask

    function automatic logic [DW-1:0] rvec();
        logic [DW-1:0] v;
        for (int j = 0; j < DW / 32; j++) v[j*32 +: 32] = $urandom();
        return v;
    endfunction

    initial begin
        logic [DW-1:0] va, vb, vc, vd, ve, vf, vg, vh, vi;
        logic [IW-1:0] seq3 [6];
        logic [IW-1:0] rw;
        va = rvec(); vb = rvec(); vc = rvec(); vd = rvec(); ve = rvec();
        vf = rvec(); vg = rvec(); vh = rvec(); vi = rvec();

        #1 rst_n = 0;
        #2;
        chk("rst_ready", in_ready, 0);
        chk("rst_vliw", vliw_inst, 0);
        chk("rst_busy", busy, 0);
        repeat (2) tick();
        rst_n = 1;
        #1 chk("post_rst_ready", in_ready, 1);
        tick();

        // Load, MVMUL, store with operand pre-loaded
        wr(0, 20'h00001); wr(1, 20'h00004); wr(2, 20'h00005);
        push1(va);
        go(2, 0);
        chk("t1_busy", busy, 1);
        tick(); chk("t1_w0", vliw_inst, 20'h00001); chk("t1_a", unit_in, va);
        chk("t1_v0", inst_valid, 1);
        tick(); chk("t1_w1", vliw_inst, 20'h00004);
        tick(); chk("t1_w2", vliw_inst, 20'h00005);
        tick(); chk("t1_done", done, 1); chk("t1_stall", stall_cnt, 0);

        // Same program starved for five cycles
        go(2, 0);
        repeat (4) begin tick(); chk("t2_bubble", inst_valid, 0); end
        in_valid = 1; in_data = vb; tick(); in_valid = 0;
        chk("t2_stall", stall_cnt, 5); chk("t2_bubble5", vliw_inst, 0);
        tick(); chk("t2_w0", vliw_inst, 20'h00001); chk("t2_b", unit_in, vb);
        tick(); tick(); tick(); chk("t2_done", done, 1);

        // Looping program, one vector per pass
        wr(0, 20'h00002); wr(1, 20'h00004);
        push1(vb); push1(vc); push1(vd);
        go(1, 2);
        seq3 = '{20'h2, 20'h4, 20'h2, 20'h4, 20'h2, 20'h4};
        for (int k = 0; k < 6; k++) begin
            tick(); chk("t3_seq", vliw_inst, seq3[k]);
            if (k == 0) chk("t3_b", unit_in, vb);
            if (k == 2) chk("t3_c", unit_in, vc);
            if (k == 4) chk("t3_d", unit_in, vd);
        end
        tick(); chk("t3_done", done, 1);

        // Fill and flush
        in_valid = 1;
        for (int k = 0; k < 4; k++) begin in_data = rvec(); tick(); end
        chk("t4_full", in_ready, 0);
        flush = 1; in_data = rvec(); tick(); flush = 0; in_valid = 0;
        chk("t4_ready", in_ready, 1);
        wr(0, 20'h00001);
        push1(ve);
        go(0, 0);
        tick(); chk("t4_w", vliw_inst, 20'h00001); chk("t4_e", unit_in, ve);
        tick(); chk("t4_done", done, 1);

        // Abort on the second issue cycle
        wr(0, 20'h00001); wr(1, 20'h00004); wr(2, 20'h00005); wr(3, 20'h00004);
        push1(vf);
        go(3, 0);
        tick(); chk("t5_w0", vliw_inst, 20'h00001);
        abort = 1; tick(); abort = 0;
        chk("t5_valid", inst_valid, 0); chk("t5_busy", busy, 0);
        repeat (3) begin tick(); chk("t5_nodone", done, 0); end

        // Program write while running is dropped
        push1(vg);
        go(3, 0);
        prog_we = 1; prog_addr = 5'd1; prog_wdata = 20'h0ABCD; tick(); prog_we = 0;
        chk("t5_perr", prog_err, 1); chk("t5_w0b", vliw_inst, 20'h00001);
        tick(); chk("t5_mem", vliw_inst, 20'h00004);
        tick(); tick(); tick(); chk("t5_done", done, 1);
        go(3, 0);
        chk("t5_perr_clr", prog_err, 0);
        abort = 1; tick(); abort = 0;

        // Asynchronous reset mid-run, then rerun retained program
        push1(vh);
        go(3, 0);
        tick(); chk("t6_w0", vliw_inst, 20'h00001);
        #2 rst_n = 0;
        #1;
        chk("t6_vliw", vliw_inst, 0); chk("t6_valid", inst_valid, 0);
        chk("t6_unit", unit_in, 0); chk("t6_busy", busy, 0);
        chk("t6_stall", stall_cnt, 0); chk("t6_ready", in_ready, 0);
        tick(); rst_n = 1; tick();
        push1(vi);
        go(3, 0);
        tick(); chk("t6_rw0", vliw_inst, 20'h00001); chk("t6_i", unit_in, vi);
        tick(); chk("t6_rw1", vliw_inst, 20'h00004);
        tick(); chk("t6_rw2", vliw_inst, 20'h00005);
        tick(); chk("t6_rw3", vliw_inst, 20'h00004);
        tick(); chk("t6_done", done, 1);

        // Randomized traffic against the model
        for (int a = 0; a < PD; a++) begin
            for (int s = 0; s < 4; s++) rw[s*OP_W +: OP_W] = 5'($urandom_range(0, 7));
            wr(a, rw);
        end
        for (int c = 0; c < 3000; c++) begin
            in_valid = ($urandom_range(0, 99) < 50);
            in_data  = rvec();
            flush    = ($urandom_range(0, 99) < 3);
            start    = ($urandom_range(0, 99) < 10);
            end_addr = 5'($urandom_range(0, 7));
            loop_cnt = 8'($urandom_range(0, 3));
            abort    = ($urandom_range(0, 99) < 2);
            prog_we  = ($urandom_range(0, 99) < 5);
            prog_addr = 5'($urandom_range(0, PD - 1));
            for (int s = 0; s < 4; s++) rw[s*OP_W +: OP_W] = 5'($urandom_range(0, 7));
            prog_wdata = rw;
            tick();
        end
        in_valid = 0; flush = 0; start = 0; prog_we = 0; abort = 1;
        repeat (3) tick();
        abort = 0;
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
